// File: rtl/sips4_ram_arbiter_if.sv
// Bundles the requester-side and RAM-side signals of the SIPS4 data-RAM arbiter.
// The slave modport is the arbiter's view; master is the requesters plus the RAM.
interface sips4_ram_arbiter_if #(
    parameter int AW = 4,
    parameter int DW = 4
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_gnt;
    logic          cpu_rvalid;
    logic [DW-1:0] cpu_rdata;

    logic          dbg_req;
    logic          dbg_we;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata;
    logic          dbg_gnt;
    logic          dbg_rvalid;
    logic [DW-1:0] dbg_rdata;

    logic          ram_wen;
    logic [AW-1:0] ram_waddr;
    logic [AW-1:0] ram_raddr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_gnt, dbg_rvalid, dbg_rdata,
        output ram_wen, ram_waddr, ram_raddr, ram_wdata,
        input  ram_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_gnt, dbg_rvalid, dbg_rdata,
        input  ram_wen, ram_waddr, ram_raddr, ram_wdata,
        output ram_rdata
    );
endinterface

// File: rtl/sips4_ram_arbiter.sv
// Shares the SIPS4 16x4 data RAM between the CPU and debug/loader ports, with registered outputs.
// Define SIPS4_ARB_RR_EN for round-robin arbitration; otherwise the debug port has fixed priority.
module sips4_ram_arbiter #(
    parameter int AW = 4,
    parameter int DW = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sips4_ram_arbiter_if.slave    bus,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ1 = 2'd2,
        READ2 = 2'd3
    } state_t;

    state_t        state_r, state_s;
    logic          win_dbg_r, win_dbg_s;
    logic          pick_dbg_s;
    logic          req_any_s;
    logic          sel_we_s;

    logic          cpu_gnt_r, cpu_gnt_s;
    logic          dbg_gnt_r, dbg_gnt_s;
    logic          cpu_rvalid_r, cpu_rvalid_s;
    logic          dbg_rvalid_r, dbg_rvalid_s;
    logic [DW-1:0] cpu_rdata_r, cpu_rdata_s;
    logic [DW-1:0] dbg_rdata_r, dbg_rdata_s;
    logic          ram_wen_r, ram_wen_s;
    logic [AW-1:0] ram_waddr_r, ram_waddr_s;
    logic [AW-1:0] ram_raddr_r, ram_raddr_s;
    logic [DW-1:0] ram_wdata_r, ram_wdata_s;
    logic          busy_r, busy_s;

`ifdef SIPS4_ARB_RR_EN
    logic          ptr_dbg_r, ptr_dbg_s;
`endif

    // Winner selection among the current requesters
    always_comb begin
        req_any_s = bus.cpu_req | bus.dbg_req;
`ifdef SIPS4_ARB_RR_EN
        if (bus.cpu_req && bus.dbg_req) begin
            pick_dbg_s = ptr_dbg_r;
        end else begin
            pick_dbg_s = bus.dbg_req;
        end
`else
        pick_dbg_s = bus.dbg_req;
`endif
    end

    // Next-state and next-output computation
    always_comb begin
        state_s      = state_r;
        win_dbg_s    = win_dbg_r;
        sel_we_s     = 1'b0;
        cpu_gnt_s    = 1'b0;
        dbg_gnt_s    = 1'b0;
        cpu_rvalid_s = 1'b0;
        dbg_rvalid_s = 1'b0;
        cpu_rdata_s  = cpu_rdata_r;
        dbg_rdata_s  = dbg_rdata_r;
        ram_waddr_s  = ram_waddr_r;
        ram_raddr_s  = ram_raddr_r;
        ram_wdata_s  = ram_wdata_r;
`ifdef SIPS4_ARB_RR_EN
        ptr_dbg_s    = ptr_dbg_r;
`endif
        case (state_r)
            IDLE: begin
                if (req_any_s) begin
                    win_dbg_s   = pick_dbg_s;
                    cpu_gnt_s   = ~pick_dbg_s;
                    dbg_gnt_s   = pick_dbg_s;
                    sel_we_s    = pick_dbg_s ? bus.dbg_we    : bus.cpu_we;
                    ram_waddr_s = pick_dbg_s ? bus.dbg_addr  : bus.cpu_addr;
                    ram_raddr_s = pick_dbg_s ? bus.dbg_addr  : bus.cpu_addr;
                    ram_wdata_s = pick_dbg_s ? bus.dbg_wdata : bus.cpu_wdata;
                    state_s     = sel_we_s ? WRITE : READ1;
`ifdef SIPS4_ARB_RR_EN
                    ptr_dbg_s   = ~pick_dbg_s;
`endif
                end else begin
                    state_s = IDLE;
                end
            end
            WRITE: state_s = IDLE;
            READ1: state_s = READ2;
            READ2: begin
                // RAM q is valid now, one cycle after the address edge
                state_s = IDLE;
                if (win_dbg_r) begin
                    dbg_rdata_s  = bus.ram_rdata;
                    dbg_rvalid_s = 1'b1;
                end else begin
                    cpu_rdata_s  = bus.ram_rdata;
                    cpu_rvalid_s = 1'b1;
                end
            end
            default: state_s = IDLE;
        endcase
        ram_wen_s = (state_s == WRITE);
        busy_s    = (state_s != IDLE);
    end

    // FSM state and winner ID register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            win_dbg_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            win_dbg_r <= win_dbg_s;
        end
    end

    // Registered outputs toward requesters and RAM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_gnt_r    <= 1'b0;
            dbg_gnt_r    <= 1'b0;
            cpu_rvalid_r <= 1'b0;
            dbg_rvalid_r <= 1'b0;
            cpu_rdata_r  <= {DW{1'b0}};
            dbg_rdata_r  <= {DW{1'b0}};
            ram_wen_r    <= 1'b0;
            ram_waddr_r  <= {AW{1'b0}};
            ram_raddr_r  <= {AW{1'b0}};
            ram_wdata_r  <= {DW{1'b0}};
            busy_r       <= 1'b0;
        end else begin
            cpu_gnt_r    <= cpu_gnt_s;
            dbg_gnt_r    <= dbg_gnt_s;
            cpu_rvalid_r <= cpu_rvalid_s;
            dbg_rvalid_r <= dbg_rvalid_s;
            cpu_rdata_r  <= cpu_rdata_s;
            dbg_rdata_r  <= dbg_rdata_s;
            ram_wen_r    <= ram_wen_s;
            ram_waddr_r  <= ram_waddr_s;
            ram_raddr_r  <= ram_raddr_s;
            ram_wdata_r  <= ram_wdata_s;
            busy_r       <= busy_s;
        end
    end

`ifdef SIPS4_ARB_RR_EN
    // Round-robin preference pointer, CPU preferred after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_dbg_r <= 1'b0;
        end else begin
            ptr_dbg_r <= ptr_dbg_s;
        end
    end
`endif

    assign bus.cpu_gnt    = cpu_gnt_r;
    assign bus.dbg_gnt    = dbg_gnt_r;
    assign bus.cpu_rvalid = cpu_rvalid_r;
    assign bus.dbg_rvalid = dbg_rvalid_r;
    assign bus.cpu_rdata  = cpu_rdata_r;
    assign bus.dbg_rdata  = dbg_rdata_r;
    assign bus.ram_wen    = ram_wen_r;
    assign bus.ram_waddr  = ram_waddr_r;
    assign bus.ram_raddr  = ram_raddr_r;
    assign bus.ram_wdata  = ram_wdata_r;
    assign busy           = busy_r;

endmodule

// File: tb/tb_sips4_ram_arbiter.sv
// Scoreboard bench for sips4_ram_arbiter: directed accesses push expected grants/read data,
// a negedge monitor pops and compares. Expectations follow SIPS4_ARB_RR_EN when defined.
module tb_sips4_ram_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    logic busy;

    sips4_ram_arbiter_if #(.AW(4), .DW(4)) bus ();

    sips4_ram_arbiter #(.AW(4), .DW(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         port;   // 0 = CPU, 1 = DBG
        bit         we;
        logic [3:0] addr;
        logic [3:0] data;
    } gnt_t;

    typedef struct {
        bit         port;
        logic [3:0] data;
    } rv_t;

    gnt_t gq[$];
    rv_t  rq[$];
    int   lat_q[$];

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    bit gap_arm  = 1'b0;
    bit gap_have = 1'b0;
    int last_gnt_cyc = 0;

    logic [3:0] mem [16];

    // Behavioural 16x4 RAM with registered read
    initial for (int i = 0; i < 16; i++) mem[i] = 4'h0;
    always @(posedge clk) begin
        if (bus.ram_wen) mem[bus.ram_waddr] <= bus.ram_wdata;
        bus.ram_rdata <= mem[bus.ram_raddr];
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        gnt_t g;
        rv_t  r;
        int   lat;
        if (!rst_n) begin
            lat_q.delete();
        end else begin
            check("one_gnt_only", {31'd0, bus.cpu_gnt & bus.dbg_gnt}, 32'd0);
            check("one_rvalid_only", {31'd0, bus.cpu_rvalid & bus.dbg_rvalid}, 32'd0);
            check("wen_only_with_gnt", {31'd0, bus.ram_wen & ~(bus.cpu_gnt | bus.dbg_gnt)}, 32'd0);
            if (bus.cpu_gnt || bus.dbg_gnt) begin
                if (gq.size() == 0) begin
                    check("unexpected_gnt_dbg", {31'd0, bus.dbg_gnt}, 32'hFFFF_FFFF);
                end else begin
                    g = gq.pop_front();
                    check("gnt_port", {31'd0, bus.dbg_gnt}, {31'd0, g.port});
                    check("gnt_wen", {31'd0, bus.ram_wen}, {31'd0, g.we});
                    check("gnt_waddr", {28'd0, bus.ram_waddr}, {28'd0, g.addr});
                    check("gnt_raddr", {28'd0, bus.ram_raddr}, {28'd0, g.addr});
                    check("gnt_busy", {31'd0, busy}, 32'd1);
                    if (g.we) check("gnt_wdata", {28'd0, bus.ram_wdata}, {28'd0, g.data});
                    else      lat_q.push_back(cyc + 2);
                    if (gap_arm) begin
                        if (gap_have) check("gnt_spacing", cyc - last_gnt_cyc, 32'd2);
                        gap_have = 1'b1;
                    end
                    last_gnt_cyc = cyc;
                end
            end
            if (bus.cpu_rvalid || bus.dbg_rvalid) begin
                if (rq.size() == 0) begin
                    check("unexpected_rvalid_dbg", {31'd0, bus.dbg_rvalid}, 32'hFFFF_FFFF);
                end else begin
                    r = rq.pop_front();
                    check("rvalid_port", {31'd0, bus.dbg_rvalid}, {31'd0, r.port});
                    check("rdata", {28'd0, r.port ? bus.dbg_rdata : bus.cpu_rdata}, {28'd0, r.data});
                    lat = (lat_q.size() != 0) ? lat_q.pop_front() : -1;
                    check("rvalid_latency", cyc, lat);
                end
            end
        end
    end

    // Flags a requester changing its command while waiting for a grant
    logic [8:0] prev_cpu, prev_dbg;
    bit         pend_cpu = 1'b0, pend_dbg = 1'b0;
    always @(negedge clk) begin
        if (rst_n && pend_cpu && bus.cpu_req && ({bus.cpu_we, bus.cpu_addr, bus.cpu_wdata} != prev_cpu)) begin
            n_fail++;
            $display("FAIL cpu_cmd_stable: got %0h, expected %0h", {bus.cpu_we, bus.cpu_addr, bus.cpu_wdata}, prev_cpu);
        end
        if (rst_n && pend_dbg && bus.dbg_req && ({bus.dbg_we, bus.dbg_addr, bus.dbg_wdata} != prev_dbg)) begin
            n_fail++;
            $display("FAIL dbg_cmd_stable: got %0h, expected %0h", {bus.dbg_we, bus.dbg_addr, bus.dbg_wdata}, prev_dbg);
        end
        pend_cpu = bus.cpu_req & ~bus.cpu_gnt;
        pend_dbg = bus.dbg_req & ~bus.dbg_gnt;
        prev_cpu = {bus.cpu_we, bus.cpu_addr, bus.cpu_wdata};
        prev_dbg = {bus.dbg_we, bus.dbg_addr, bus.dbg_wdata};
    end

    task automatic drive_req(input bit port, input bit we, input logic [3:0] addr, input logic [3:0] data);
        if (port) begin
            bus.dbg_we = we; bus.dbg_addr = addr; bus.dbg_wdata = data; bus.dbg_req = 1'b1;
        end else begin
            bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = data; bus.cpu_req = 1'b1;
        end
    endtask

    // Returns at the negedge inside the grant cycle
    task automatic wait_gnt(input bit port);
        int  n;
        bit  seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 200) begin
            @(negedge clk);
            n++;
            seen = port ? bus.dbg_gnt : bus.cpu_gnt;
        end
        check(port ? "dbg_gnt_timeout" : "cpu_gnt_timeout", {31'd0, seen}, 32'd1);
    endtask

    task automatic drop_req(input bit port);
        if (port) bus.dbg_req = 1'b0;
        else      bus.cpu_req = 1'b0;
    endtask

    task automatic access(input bit port, input bit we, input logic [3:0] addr, input logic [3:0] data);
        drive_req(port, we, addr, data);
        wait_gnt(port);
        @(posedge clk); #1;
        drop_req(port);
    endtask

    function automatic gnt_t mk_g(input bit port, input bit we, input logic [3:0] addr, input logic [3:0] data);
        gnt_t g;
        g.port = port; g.we = we; g.addr = addr; g.data = data;
        return g;
    endfunction

    function automatic rv_t mk_r(input bit port, input logic [3:0] data);
        rv_t r;
        r.port = port; r.data = data;
        return r;
    endfunction

    initial begin
        rst_n = 1'b0;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 4'h0; bus.cpu_wdata = 4'h0;
        bus.dbg_req = 1'b0; bus.dbg_we = 1'b0; bus.dbg_addr = 4'h0; bus.dbg_wdata = 4'h0;

        // Reset with both ports requesting, then first arbitration
`ifdef SIPS4_ARB_RR_EN
        gq.push_back(mk_g(1'b0, 1'b1, 4'h1, 4'h7));
        gq.push_back(mk_g(1'b1, 1'b1, 4'h2, 4'h3));
`else
        gq.push_back(mk_g(1'b1, 1'b1, 4'h2, 4'h3));
        gq.push_back(mk_g(1'b0, 1'b1, 4'h1, 4'h7));
`endif
        fork
            access(1'b0, 1'b1, 4'h1, 4'h7);
            access(1'b1, 1'b1, 4'h2, 4'h3);
            begin
                repeat (3) @(negedge clk);
                check("rst_cpu_gnt", {31'd0, bus.cpu_gnt}, 32'd0);
                check("rst_dbg_gnt", {31'd0, bus.dbg_gnt}, 32'd0);
                check("rst_cpu_rvalid", {31'd0, bus.cpu_rvalid}, 32'd0);
                check("rst_dbg_rvalid", {31'd0, bus.dbg_rvalid}, 32'd0);
                check("rst_ram_wen", {31'd0, bus.ram_wen}, 32'd0);
                check("rst_busy", {31'd0, busy}, 32'd0);
                check("rst_ram_waddr", {28'd0, bus.ram_waddr}, 32'd0);
                @(posedge clk); #1;
                rst_n = 1'b1;
            end
        join

        // CPU write then read back
        gq.push_back(mk_g(1'b0, 1'b1, 4'h5, 4'hA));
        gq.push_back(mk_g(1'b0, 1'b0, 4'h5, 4'h0));
        rq.push_back(mk_r(1'b0, 4'hA));
        access(1'b0, 1'b1, 4'h5, 4'hA);
        access(1'b0, 1'b0, 4'h5, 4'h0);

        // Contention: continuous writes from both ports
`ifdef SIPS4_ARB_RR_EN
        gq.push_back(mk_g(1'b1, 1'b1, 4'hC, 4'h4));
        gq.push_back(mk_g(1'b0, 1'b1, 4'h8, 4'h1));
        gq.push_back(mk_g(1'b1, 1'b1, 4'hD, 4'h5));
        gq.push_back(mk_g(1'b0, 1'b1, 4'h9, 4'h2));
        gq.push_back(mk_g(1'b1, 1'b1, 4'hE, 4'h6));
        gq.push_back(mk_g(1'b0, 1'b1, 4'hA, 4'h3));
`else
        gq.push_back(mk_g(1'b1, 1'b1, 4'hC, 4'h4));
        gq.push_back(mk_g(1'b1, 1'b1, 4'hD, 4'h5));
        gq.push_back(mk_g(1'b1, 1'b1, 4'hE, 4'h6));
        gq.push_back(mk_g(1'b0, 1'b1, 4'h8, 4'h1));
        gq.push_back(mk_g(1'b0, 1'b1, 4'h9, 4'h2));
        gq.push_back(mk_g(1'b0, 1'b1, 4'hA, 4'h3));
`endif
        gap_arm = 1'b1;
        fork
            begin
                access(1'b0, 1'b1, 4'h8, 4'h1);
                access(1'b0, 1'b1, 4'h9, 4'h2);
                access(1'b0, 1'b1, 4'hA, 4'h3);
            end
            begin
                access(1'b1, 1'b1, 4'hC, 4'h4);
                access(1'b1, 1'b1, 4'hD, 4'h5);
                access(1'b1, 1'b1, 4'hE, 4'h6);
            end
        join
        gap_arm = 1'b0;

        // DBG read so dbg_rdata is non-zero before the reset test
        gq.push_back(mk_g(1'b1, 1'b0, 4'hC, 4'h0));
        rq.push_back(mk_r(1'b1, 4'h4));
        access(1'b1, 1'b0, 4'hC, 4'h0);
        repeat (4) @(negedge clk);
        check("dbg_rdata_held", {28'd0, bus.dbg_rdata}, 32'h4);

        // Reset during READ2 of a DBG read of addr 3
        gq.push_back(mk_g(1'b1, 1'b0, 4'h3, 4'h0));
        drive_req(1'b1, 1'b0, 4'h3, 4'h0);
        wait_gnt(1'b1);
        @(posedge clk); #1;
        drop_req(1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrd_dbg_rvalid", {31'd0, bus.dbg_rvalid}, 32'd0);
        check("midrd_dbg_rdata", {28'd0, bus.dbg_rdata}, 32'd0);
        check("midrd_busy", {31'd0, busy}, 32'd0);
        check("midrd_ram_wen", {31'd0, bus.ram_wen}, 32'd0);
        repeat (2) @(negedge clk);
        check("midrd_dbg_rvalid_late", {31'd0, bus.dbg_rvalid}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_busy", {31'd0, busy}, 32'd0);

        // CPU request withdrawn while a DBG read is in flight
        gq.push_back(mk_g(1'b1, 1'b0, 4'hD, 4'h0));
        rq.push_back(mk_r(1'b1, 4'h5));
        drive_req(1'b1, 1'b0, 4'hD, 4'h0);
        wait_gnt(1'b1);
        #2;
        drive_req(1'b0, 1'b1, 4'hF, 4'h9);
        @(posedge clk); #1;
        drop_req(1'b1);
        drop_req(1'b0);
        repeat (6) @(negedge clk);
        check("withdraw_idle", {31'd0, busy}, 32'd0);

        // Address F must still hold its initial zero
        gq.push_back(mk_g(1'b0, 1'b0, 4'hF, 4'h0));
        rq.push_back(mk_r(1'b0, 4'h0));
        access(1'b0, 1'b0, 4'hF, 4'h0);
        repeat (5) @(negedge clk);

        check("gnt_queue_drained", gq.size(), 32'd0);
        check("rvalid_queue_drained", rq.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
